counter_array_ctrl: RTL and testbench

COUNTER_ARRAY_CTRL -- requirements
Module: counter_array_ctrl

---
 rtl/counter_array_pkg.sv | 11 +
 rtl/counter_array_ctrl_if.sv | 31 +++
 rtl/counter_array_ctrl_lane_accum.sv | 21 ++
 rtl/counter_array_ctrl.sv | 94 +++++++++
 tb/tb_counter_array_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_array_pkg.sv
// Shared types and constants for the counter-array sequencer.
package counter_array_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // A healthy job never needs more count cycles than the largest lane magnitude.
  function automatic int unsigned timeout_cycles(input int unsigned width);
    return (32'd1 << (width - 32'd1)) + 32'd1;
  endfunction

endpackage

// File: rtl/counter_array_ctrl_if.sv
// Bundle of upstream, downstream and counter-array signals around the sequencer.
interface counter_array_ctrl_if #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIM-1:0][WIDTH-1:0] in_vec;
  logic                      abort;
  logic [DIM-1:0][WIDTH-1:0] ca_in_array;
  logic                      ca_save;
  logic                      ca_en;
  logic                      ca_done;
  logic [DIM-1:0]            ca_neg;
  logic [DIM-1:0]            ca_unary;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIM-1:0][WIDTH-1:0] out_sum;
  logic [WIDTH:0]            out_cycles;
  logic                      out_err;

  modport master (
    input  in_valid, in_vec, abort, ca_done, ca_neg, ca_unary, out_ready,
    output in_ready, ca_in_array, ca_save, ca_en, out_valid, out_sum, out_cycles, out_err
  );

  modport slave (
    output in_valid, in_vec, abort, ca_done, ca_neg, ca_unary, out_ready,
    input  in_ready, ca_in_array, ca_save, ca_en, out_valid, out_sum, out_cycles, out_err
  );
endinterface

// File: rtl/counter_array_ctrl_lane_accum.sv
// Per-lane signed accumulator rebuilding a value from unary/sign pulses.
module lane_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic             neg,
  output logic [WIDTH-1:0] acc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= neg ? acc - 1'b1 : acc + 1'b1;
    end
  end

endmodule

// File: rtl/counter_array_ctrl.sv
// Sequences one vector through an external counter array and rebuilds it per lane.
// One job in flight; in_ready only in IDLE, result held in DONE until taken.
module counter_array_ctrl
  import counter_array_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  counter_array_ctrl_if.master bus
);

  localparam logic [WIDTH:0] TIMEOUT = (WIDTH+1)'(timeout_cycles(WIDTH));

  state_t                    state;
  logic [DIM-1:0][WIDTH-1:0] vec_q;
  logic [DIM-1:0][WIDTH-1:0] sum;
  logic [WIDTH:0]            cycles;
  logic [WIDTH:0]            cycles_nxt;
  logic                      err;
  logic                      run_step;

  assign cycles_nxt = cycles + 1'b1;
  assign run_step   = (state == RUN) && !bus.ca_done && !bus.abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vec_q  <= '0;
      cycles <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vec_q <= bus.in_vec;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            cycles <= '0;
            err    <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.ca_done) begin
            state <= DONE;
          end else begin
            cycles <= cycles_nxt;
            // Counter array never reported done: give up rather than spin forever.
            if (cycles_nxt == TIMEOUT) begin
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    lane_accum #(.WIDTH(WIDTH)) u_accum (
      .clk   (clk),
      .reset (reset),
      .clear (state == LOAD),
      .step  (run_step && bus.ca_unary[i]),
      .neg   (bus.ca_neg[i]),
      .acc   (sum[i])
    );
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.ca_save     = (state == LOAD);
  assign bus.ca_en       = (state == RUN) && !bus.ca_done;
  assign bus.ca_in_array = vec_q;
  assign bus.out_sum     = sum;
  assign bus.out_cycles  = cycles;
  assign bus.out_err     = err;

endmodule

// File: tb/tb_counter_array_ctrl.sv
// Bench pairing counter_array_ctrl with a behavioural counter array (magnitude down-counters).
module tb_counter_array_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic stuck;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  counter_array_ctrl_if #(.DIM(4), .WIDTH(8)) bus ();

  counter_array_ctrl #(.DIM(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Counter array model: loads |lane| and sign, counts magnitudes down to zero.
  logic [3:0][7:0] mag;
  logic [3:0]      sgn;

  always @(posedge clk) begin
    if (reset) begin
      mag <= '0;
      sgn <= '0;
    end else if (bus.ca_save) begin
      for (int i = 0; i < 4; i++) begin
        sgn[i] <= bus.ca_in_array[i][7];
        mag[i] <= bus.ca_in_array[i][7] ? 8'd0 - bus.ca_in_array[i] : bus.ca_in_array[i];
      end
    end else if (bus.ca_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mag[i] != 8'd0) mag[i] <= mag[i] - 8'd1;
      end
    end
  end

  always_comb begin
    bus.ca_unary = '0;
    for (int i = 0; i < 4; i++) begin
      bus.ca_unary[i] = stuck || (mag[i] != 8'd0);
    end
  end
  assign bus.ca_done = !stuck && (mag == '0);
  assign bus.ca_neg  = stuck ? 4'b0000 : sgn;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [3:0][7:0] mk(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  always @(negedge clk) begin
    if (!reset) chk("save_en_exclusive", int'(bus.ca_save & bus.ca_en), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0][7:0] vec);
    bus.in_vec   = vec;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [3:0][7:0] vec,
                         input logic [3:0][7:0] exp_sum, input int exp_cyc,
                         input int exp_lat, input int exp_err, input int hold);
    int              cyc;
    logic [8:0]      c0;
    logic [3:0][7:0] s0;
    chk({tag, "_in_ready_idle"}, int'(bus.in_ready), 1);
    accept(vec);
    cyc = 1;
    chk({tag, "_load_save"}, int'(bus.ca_save), 1);
    chk({tag, "_load_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_ca_in_array"}, int'(bus.ca_in_array), int'(vec));
    while (!bus.out_valid && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 2) chk({tag, "_run_save"}, int'(bus.ca_save), 0);
    end
    if (!bus.out_valid) begin
      chk({tag, "_out_valid_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_cycles"}, int'(bus.out_cycles), exp_cyc);
    chk({tag, "_err"}, int'(bus.out_err), exp_err);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_sum%0d", tag, i), int'($signed(bus.out_sum[i])), int'($signed(exp_sum[i])));
    end
    c0 = bus.out_cycles;
    s0 = bus.out_sum;
    for (int k = 0; k < hold; k++) begin
      bus.abort = k[0];
      tick();
      chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({tag, "_hold_in_ready"}, int'(bus.in_ready), 0);
      chk({tag, "_hold_cycles"}, int'(bus.out_cycles), int'(c0));
      chk({tag, "_hold_sum"}, int'(bus.out_sum), int'(s0));
    end
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_post_in_ready"}, int'(bus.in_ready), 1);
  endtask

  typedef struct {
    logic [3:0][7:0] vec;
    int              cyc;
    int              lat;
  } vec_t;

  vec_t tbl [5];
  int   hits;

  initial begin
    tbl[0] = '{mk(3, -2, 0, 5),       5,   8};
    tbl[1] = '{mk(0, 0, 0, 0),        0,   3};
    tbl[2] = '{mk(-128, 127, 1, -1), 128, 131};
    tbl[3] = '{mk(-7, 2, -3, 0),      7,  10};
    tbl[4] = '{mk(1, 1, 1, 1),        1,   4};

    reset         = 1'b1;
    stuck         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_ca_save", int'(bus.ca_save), 0);
    chk("rst_ca_en", int'(bus.ca_en), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_cycles", int'(bus.out_cycles), 0);
    chk("rst_ca_in_array", int'(bus.ca_in_array), 0);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 5; t++) begin
      run_job($sformatf("vec%0d", t), tbl[t].vec, tbl[t].vec, tbl[t].cyc, tbl[t].lat, 0, 0);
    end

    // Abort in RUN at cycle 4, then a fresh job.
    accept(mk(10, 0, 0, 0));
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_run_in_ready", int'(bus.in_ready), 1);
    chk("abort_run_ca_en", int'(bus.ca_en), 0);
    chk("abort_run_ca_save", int'(bus.ca_save), 0);
    hits = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) hits++;
      tick();
    end
    chk("abort_run_no_valid", hits, 0);
    run_job("after_abort", mk(1, 1, 1, 1), mk(1, 1, 1, 1), 1, 4, 0, 0);

    // Abort while in LOAD.
    accept(mk(4, 4, 4, 4));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_load_in_ready", int'(bus.in_ready), 1);
    chk("abort_load_ca_en", int'(bus.ca_en), 0);

    // Downstream stall with abort toggling in DONE.
    run_job("hold", mk(2, -1, 0, 0), mk(2, -1, 0, 0), 2, 5, 0, 10);

    // Reset mid-RUN beats abort and ca_done.
    accept(mk(5, 5, 5, 5));
    repeat (3) tick();
    reset     = 1'b1;
    bus.abort = 1'b1;
    tick();
    reset     = 1'b0;
    bus.abort = 1'b0;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_ca_en", int'(bus.ca_en), 0);
    chk("midrst_out_sum", int'(bus.out_sum), 0);
    chk("midrst_out_cycles", int'(bus.out_cycles), 0);
    chk("midrst_ca_in_array", int'(bus.ca_in_array), 0);
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) hits++;
      tick();
    end
    chk("midrst_no_valid", hits, 0);

    // Stuck counter array: timeout after 129 count cycles, lanes wrap to -127.
    stuck = 1'b1;
    run_job("stuck", mk(1, 0, 0, 0), mk(-127, -127, -127, -127), 129, 131, 1, 0);
    stuck = 1'b0;
    tick();
    run_job("err_clear", mk(0, 0, 0, 0), mk(0, 0, 0, 0), 0, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
